vi_pipe_chain: RTL

//  Parametrised multi-stage pipeline register chain for long-latency units (integer multiplier and

---
 rtl/vi_pkg.sv | 20 ++
 rtl/vi_pipe_stage.sv | 40 ++++
 rtl/vi_pipe_chain.sv | 114 +++++++++++
 3 files changed

// File: rtl/vi_pkg.sv
// Shared constants, per-stage control record and hazard helper for the long-latency pipe chain.
package vi_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       instr;
        logic [XLEN-1:0]       pc;
    } pipe_ctrl_t;

    // A stage blocks a reader only if it is live, writes, and targets a non-zero register.
    function automatic logic addr_hit(input pipe_ctrl_t ctrl, input logic [REG_ADDR_W-1:0] query);
        return ctrl.valid & ctrl.we & (ctrl.addr == query) & (query != {REG_ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/vi_pipe_stage.sv
// One register stage of the pipe chain: clear beats load, load beats hold.
module vi_pipe_stage
    import vi_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  pipe_ctrl_t        ctrl_d,
    input  logic [DATA_W-1:0] data_d,
    output pipe_ctrl_t        ctrl_q,
    output logic [DATA_W-1:0] data_q
);

    pipe_ctrl_t        ctrl_r;
    logic [DATA_W-1:0] data_r;

    // Stage register; a clear only kills valid/we, the payload is left as don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_r <= '0;
            data_r <= {DATA_W{1'b0}};
        end else if (clear) begin
            ctrl_r.valid <= 1'b0;
            ctrl_r.we    <= 1'b0;
        end else if (load) begin
            ctrl_r <= ctrl_d;
            data_r <= data_d;
        end else begin
            ctrl_r <= ctrl_r;
            data_r <= data_r;
        end
    end

    assign ctrl_q = ctrl_r;
    assign data_q = data_r;

endmodule

// File: rtl/vi_pipe_chain.sv
// Parametrised register chain for long-latency units with stall/flush, compute taps,
// pending-write hazard queries and an occupancy count.
module vi_pipe_chain #(
    parameter int DEPTH  = 5,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int XLEN   = 32
) (
    input  logic                         clk_i,
    input  logic                         rsn_i,
    input  logic                         stall_i,
    input  logic                         flush_i,
    input  logic                         valid_i,
    input  logic [XLEN-1:0]              instr_i,
    input  logic [XLEN-1:0]              pc_i,
    input  logic [ADDR_W-1:0]            write_addr_i,
    input  logic                         write_enable_i,
    input  logic [DATA_W-1:0]            write_data_i,
    output logic [DEPTH*DATA_W-1:0]      stage_data_o,
    input  logic [DEPTH*DATA_W-1:0]      stage_result_i,
    input  logic [ADDR_W-1:0]            query_a_i,
    input  logic [ADDR_W-1:0]            query_b_i,
    output logic                         pending_a_o,
    output logic                         pending_b_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
    output logic                         valid_o,
    output logic [XLEN-1:0]              instr_o,
    output logic [XLEN-1:0]              pc_o,
    output logic [ADDR_W-1:0]            write_addr_o,
    output logic                         write_enable_o,
    output logic [DATA_W-1:0]            write_data_o
);
    import vi_pkg::*;

    localparam int OCC_W = $clog2(DEPTH+1);

    pipe_ctrl_t        ctrl_q_s [DEPTH];
    logic [DATA_W-1:0] data_q_s [DEPTH];
    pipe_ctrl_t        issue_ctrl_s;
    logic              load_s;
    logic [OCC_W-1:0]  occ_s;
    logic              pend_a_s;
    logic              pend_b_s;
    logic              unused_result_s;

    assign load_s = ~stall_i;

    // Stage-0 control word; a bubble never carries a write enable.
    always_comb begin
        issue_ctrl_s       = '0;
        issue_ctrl_s.valid = valid_i;
        issue_ctrl_s.we    = write_enable_i & valid_i;
        issue_ctrl_s.addr  = write_addr_i;
        issue_ctrl_s.instr = instr_i;
        issue_ctrl_s.pc    = pc_i;
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            vi_pipe_stage #(.DATA_W(DATA_W)) u_stage (
                .clk    (clk_i),
                .rst_n  (rsn_i),
                .load   (load_s),
                .clear  (flush_i),
                .ctrl_d (issue_ctrl_s),
                .data_d (write_data_i),
                .ctrl_q (ctrl_q_s[k]),
                .data_q (data_q_s[k])
            );
        end else begin : g_body
            // Control rides along unchanged; the payload comes from the previous stage's compute tap.
            vi_pipe_stage #(.DATA_W(DATA_W)) u_stage (
                .clk    (clk_i),
                .rst_n  (rsn_i),
                .load   (load_s),
                .clear  (flush_i),
                .ctrl_d (ctrl_q_s[k-1]),
                .data_d (stage_result_i[(k-1)*DATA_W +: DATA_W]),
                .ctrl_q (ctrl_q_s[k]),
                .data_q (data_q_s[k])
            );
        end
        assign stage_data_o[k*DATA_W +: DATA_W] = data_q_s[k];
    end

    // The last tap has no downstream stage to feed.
    assign unused_result_s = ^stage_result_i[DEPTH*DATA_W-1 -: DATA_W];

    // Pending-write search and live-stage count across every stage, output stage included.
    always_comb begin
        pend_a_s = 1'b0;
        pend_b_s = 1'b0;
        occ_s    = {OCC_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            pend_a_s = pend_a_s | addr_hit(ctrl_q_s[k], query_a_i);
            pend_b_s = pend_b_s | addr_hit(ctrl_q_s[k], query_b_i);
            occ_s    = occ_s + OCC_W'(ctrl_q_s[k].valid);
        end
    end

    assign pending_a_o    = pend_a_s;
    assign pending_b_o    = pend_b_s;
    assign occupancy_o    = occ_s;

    assign valid_o        = ctrl_q_s[DEPTH-1].valid;
    assign instr_o        = ctrl_q_s[DEPTH-1].instr;
    assign pc_o           = ctrl_q_s[DEPTH-1].pc;
    assign write_addr_o   = ctrl_q_s[DEPTH-1].addr;
    assign write_data_o   = data_q_s[DEPTH-1];
    // Register zero is hard-wired, so a write to it is never presented to writeback.
    assign write_enable_o = ctrl_q_s[DEPTH-1].valid & ctrl_q_s[DEPTH-1].we &
                            (ctrl_q_s[DEPTH-1].addr != {ADDR_W{1'b0}});

endmodule
